// File: rtl/reg_bank_pkg.sv
// Shared defaults, command encodings and FSM state enum for reg_bank_master.
package reg_bank_pkg;

  localparam int unsigned DATA_W_DEF   = 4;
  localparam int unsigned ADDR_W_DEF   = 4;
  localparam int unsigned NUM_REGS_DEF = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_DUMP  = 2'b10,
    OP_CLEAR = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RESP,
    S_DUMP_RD,
    S_DUMP_RSP,
    S_CLEAR
  } state_e;

endpackage

// File: rtl/reg_bank_master.sv
// Command-driven master for an external dual-read/single-write register bank.
// Optional bulk clear when REG_BANK_MASTER_CLEAR_EN is defined.
module reg_bank_master
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  output logic              rsp_last,
  output logic [ADDR_W-1:0] addr_ra,
  output logic [ADDR_W-1:0] addr_rb,
  input  logic [DATA_W-1:0] dat_out_ra,
  input  logic [DATA_W-1:0] dat_out_rb,
  output logic [ADDR_W-1:0] addr_w,
  output logic [DATA_W-1:0] dat_w,
  output logic              reg_write
);

  localparam int unsigned IDX_W = ADDR_W - 1;

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [IDX_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_rsp_addr;
  logic [DATA_W-1:0] r_rsp_a;
  logic [DATA_W-1:0] r_rsp_b;
  logic              r_rsp_last;
`ifdef REG_BANK_MASTER_CLEAR_EN
  logic [ADDR_W-1:0] r_clr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_idx      <= '0;
      r_rsp_addr <= '0;
      r_rsp_a    <= '0;
      r_rsp_b    <= '0;
      r_rsp_last <= 1'b0;
`ifdef REG_BANK_MASTER_CLEAR_EN
      r_clr      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr <= cmd_addr;
            r_data <= cmd_data;
            case (cmd_op_e'(cmd_op))
              OP_WRITE: r_state <= S_WRITE;
              OP_READ:  r_state <= S_READ;
              OP_DUMP: begin
                r_idx   <= '0;
                r_state <= S_DUMP_RD;
              end
`ifdef REG_BANK_MASTER_CLEAR_EN
              OP_CLEAR: begin
                r_clr   <= '0;
                r_state <= S_CLEAR;
              end
`else
              OP_CLEAR: r_state <= S_IDLE;
`endif
              default:  r_state <= S_IDLE;
            endcase
          end
        end
        S_WRITE: r_state <= S_IDLE;
        S_READ: begin
          r_rsp_addr <= r_addr;
          r_rsp_a    <= dat_out_ra;
          r_rsp_b    <= '0;
          r_rsp_last <= 1'b1;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_last <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_DUMP_RD: begin
          r_rsp_addr <= {r_idx, 1'b0};
          r_rsp_a    <= dat_out_ra;
          r_rsp_b    <= dat_out_rb;
          r_rsp_last <= (r_idx == '1);
          r_state    <= S_DUMP_RSP;
        end
        S_DUMP_RSP: begin
          if (rsp_ready) begin
            if (r_rsp_last) begin
              r_idx      <= '0;
              r_rsp_last <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_DUMP_RD;
            end
          end
        end
`ifdef REG_BANK_MASTER_CLEAR_EN
        S_CLEAR: begin
          // Exit on the last address so the counter never wraps back onto 0.
          if (r_clr == '1) begin
            r_clr   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_clr <= r_clr + 1'b1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_ra   = '0;
    addr_rb   = '0;
    addr_w    = '0;
    dat_w     = '0;
    reg_write = 1'b0;
    case (r_state)
      S_WRITE: begin
        reg_write = 1'b1;
        addr_w    = r_addr;
        dat_w     = r_data;
      end
      S_READ: addr_ra = r_addr;
      S_DUMP_RD: begin
        addr_ra = {r_idx, 1'b0};
        addr_rb = {r_idx, 1'b1};
      end
`ifdef REG_BANK_MASTER_CLEAR_EN
      S_CLEAR: begin
        reg_write = 1'b1;
        addr_w    = r_clr;
      end
`endif
      default: ;
    endcase
  end

  assign cmd_ready  = (r_state == S_IDLE) && !rst;
  assign rsp_valid  = (r_state == S_RESP) || (r_state == S_DUMP_RSP);
  assign rsp_addr   = r_rsp_addr;
  assign rsp_data_a = r_rsp_a;
  assign rsp_data_b = r_rsp_b;
  assign rsp_last   = r_rsp_last;

endmodule

// File: tb/tb_reg_bank_master.sv
// Self-checking bench for reg_bank_master with a behavioural bank model.
module tb_reg_bank_master;
  import reg_bank_pkg::*;

  localparam int DW = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready, rsp_last;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data_a, rsp_data_b;
  logic [AW-1:0] addr_ra, addr_rb, addr_w;
  logic [DW-1:0] dat_out_ra, dat_out_rb, dat_w;
  logic          reg_write;

  always #5 clk = ~clk;

  reg_bank_master #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b), .rsp_last(rsp_last),
    .addr_ra(addr_ra), .addr_rb(addr_rb),
    .dat_out_ra(dat_out_ra), .dat_out_rb(dat_out_rb),
    .addr_w(addr_w), .dat_w(dat_w), .reg_write(reg_write)
  );

  // External bank: combinational reads, clocked write; also logs write pulses.
  logic [DW-1:0] bank [16] = '{default: '0};
  assign dat_out_ra = bank[addr_ra];
  assign dat_out_rb = bank[addr_rb];

  int cyc = 0;
  int wr_addr_q[$];
  int wr_dat_q[$];
  int wr_cyc_q[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reg_write) begin
      bank[addr_w] <= dat_w;
      wr_addr_q.push_back(int'(addr_w));
      wr_dat_q.push_back(int'(dat_w));
      wr_cyc_q.push_back(cyc);
    end
  end

  int model[16];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic send(input logic [1:0] op, input int a, input int d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a[AW-1:0];
      cmd_data  = d[DW-1:0];
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic get_rsp(output bit ok, output int ra, output int a, output int b, output int last);
    ok = 1'b0;
    ra = 0; a = 0; b = 0; last = 0;
    for (int k = 0; k < 200; k++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      ra = int'(rsp_addr); a = int'(rsp_data_a); b = int'(rsp_data_b); last = int'(rsp_last);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_last, reg_write} !== 4'b0000)
      $display("FAIL reset_ctrl got %b want 0000", {cmd_ready, rsp_valid, rsp_last, reg_write});
    else n_pass++;
    n_checks++;
    if ({rsp_addr, rsp_data_a, rsp_data_b, addr_ra, addr_rb, addr_w, dat_w} !== '0)
      $display("FAIL reset_outputs got %h want 0",
               {rsp_addr, rsp_data_a, rsp_data_b, addr_ra, addr_rb, addr_w, dat_w});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", cmd_ready);
    else n_pass++;
  endtask

  task automatic test_write;
    int wa[4] = '{3, 10, 7, 0};
    int wd[4] = '{2, 8, 13, 9};
    bit ok;
    int n0, seen_rsp;
    for (int i = 0; i < 4; i++) begin
      n0 = wr_addr_q.size();
      seen_rsp = 0;
      send(OP_WRITE, wa[i], wd[i], ok);
      for (int k = 0; k < 3; k++) begin
        if (rsp_valid) seen_rsp = 1;
        @(negedge clk);
      end
      model[wa[i]] = wd[i];
      n_checks++;
      if (!ok || wr_addr_q.size() != n0 + 1)
        $display("FAIL write_pulse_count got %0d want %0d", wr_addr_q.size() - n0, 1);
      else n_pass++;
      n_checks++;
      if (wr_addr_q.size() < n0 + 1 || wr_addr_q[n0] != wa[i] || wr_dat_q[n0] != wd[i])
        $display("FAIL write_fields got addr=%0d dat=%0d want addr=%0d dat=%0d",
                 (wr_addr_q.size() > n0) ? wr_addr_q[n0] : -1,
                 (wr_dat_q.size() > n0) ? wr_dat_q[n0] : -1, wa[i], wd[i]);
      else n_pass++;
      n_checks++;
      if (seen_rsp != 0) $display("FAIL write_no_rsp got rsp_valid=1 want 0");
      else n_pass++;
    end
  endtask

  task automatic test_read(input int addr);
    bit ok;
    int ra, a, b, last;
    send(OP_READ, addr, 0, ok);
    n_checks++;
    if (!ok || rsp_valid !== 1'b0) $display("FAIL read_latency_early got %b want 0", rsp_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1) $display("FAIL read_latency got rsp_valid=%b want 1", rsp_valid);
    else n_pass++;
    get_rsp(ok, ra, a, b, last);
    n_checks++;
    if (!ok || a != model[addr] || b != 0 || last != 1 || ra != addr)
      $display("FAIL read_rsp addr=%0d got a=%0d b=%0d last=%0d ra=%0d want a=%0d b=0 last=1 ra=%0d",
               addr, a, b, last, ra, model[addr], addr);
    else n_pass++;
  endtask

  task automatic test_dump(input int stall_at);
    bit ok, stable;
    int ra, a, b, last, n0;
    logic [AW+2*DW:0] snap;
    n0 = wr_addr_q.size();
    send(OP_DUMP, 0, 0, ok);
    n_checks++;
    if (!ok) $display("FAIL dump_accept got timeout want accepted");
    else n_pass++;
    for (int r = 0; r < 8; r++) begin
      if (r == stall_at) begin
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
          if (rsp_valid) begin ok = 1'b1; break; end
          @(negedge clk);
        end
        snap = {rsp_addr, rsp_data_a, rsp_data_b, rsp_last};
        stable = ok;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (!rsp_valid || {rsp_addr, rsp_data_a, rsp_data_b, rsp_last} !== snap) stable = 1'b0;
        end
        n_checks++;
        if (!stable) $display("FAIL dump_stall_stable got %h want %h", {rsp_addr, rsp_data_a, rsp_data_b, rsp_last}, snap);
        else n_pass++;
      end
      get_rsp(ok, ra, a, b, last);
      n_checks++;
      if (!ok || ra != 2 * r || a != model[2*r] || b != model[2*r+1] || last != (r == 7))
        $display("FAIL dump_rsp%0d got ra=%0d a=%0d b=%0d last=%0d want ra=%0d a=%0d b=%0d last=%0d",
                 r, ra, a, b, last, 2 * r, model[2*r], model[2*r+1], (r == 7));
      else n_pass++;
    end
    rsp_ready = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b0;
    end
    rsp_ready = 1'b0;
    n_checks++;
    if (!ok || cmd_ready !== 1'b1 || wr_addr_q.size() != n0)
      $display("FAIL dump_end got extra_rsp=%0d ready=%b writes=%0d want 0 1 0", !ok, cmd_ready, wr_addr_q.size() - n0);
    else n_pass++;
  endtask

  task automatic test_clear;
    bit ok, seen_rsp;
    int n0;
    n0 = wr_addr_q.size();
    seen_rsp = 1'b0;
    send(OP_CLEAR, 5, 7, ok);
`ifdef REG_BANK_MASTER_CLEAR_EN
    for (int k = 0; k < 40 && !cmd_ready; k++) begin
      if (rsp_valid) seen_rsp = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (!ok || wr_addr_q.size() != n0 + 16 || seen_rsp)
      $display("FAIL clear_pulses got %0d rsp=%0d want 16 rsp=0", wr_addr_q.size() - n0, seen_rsp);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (wr_addr_q.size() < n0 + 16 || wr_addr_q[n0+i] != i || wr_dat_q[n0+i] != 0 ||
          wr_cyc_q[n0+i] != wr_cyc_q[n0] + i)
        $display("FAIL clear_pulse%0d got addr=%0d dat=%0d want addr=%0d dat=0 consecutive", i,
                 (wr_addr_q.size() > n0 + i) ? wr_addr_q[n0+i] : -1,
                 (wr_dat_q.size() > n0 + i) ? wr_dat_q[n0+i] : -1, i);
      else n_pass++;
    end
    for (int i = 0; i < 16; i++) model[i] = 0;
`else
    n_checks++;
    if (!ok || cmd_ready !== 1'b1) $display("FAIL clear_idle_next got ready=%b want 1", cmd_ready);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid) seen_rsp = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (wr_addr_q.size() != n0 || seen_rsp)
      $display("FAIL clear_disabled got writes=%0d rsp=%0d want 0 0", wr_addr_q.size() - n0, seen_rsp);
    else n_pass++;
`endif
    test_read(7);
  endtask

  task automatic test_random;
    bit ok;
    int ra, a, b, last, n0, addr, data;
    for (int i = 0; i < 40; i++) begin
      addr = (i % 4 == 1) ? addr : int'($urandom_range(0, 15));
      data = int'($urandom_range(0, 15));
      if (i % 4 == 0 || $urandom_range(0, 1) == 0) begin
        n0 = wr_addr_q.size();
        send(OP_WRITE, addr, data, ok);
        @(negedge clk);
        model[addr] = data;
        n_checks++;
        if (!ok || wr_addr_q.size() != n0 + 1 || wr_addr_q[n0] != addr || wr_dat_q[n0] != data)
          $display("FAIL rand_write%0d got n=%0d want addr=%0d dat=%0d", i, wr_addr_q.size() - n0, addr, data);
        else n_pass++;
      end else begin
        send(OP_READ, addr, 0, ok);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        get_rsp(ok, ra, a, b, last);
        n_checks++;
        if (!ok || a != model[addr] || b != 0 || last != 1 || ra != addr)
          $display("FAIL rand_read%0d addr=%0d got a=%0d b=%0d last=%0d want a=%0d", i, addr, a, b, last, model[addr]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_dump;
    bit ok, seen;
    int ra, a, b, last, n0;
    send(OP_DUMP, 0, 0, ok);
    for (int r = 0; r < 3; r++) get_rsp(ok, ra, a, b, last);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n0 = wr_addr_q.size();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (!ok || rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || rsp_last !== 1'b0)
      $display("FAIL rst_mid_dump got valid=%b ready=%b last=%b want 0 0 0", rsp_valid, cmd_ready, rsp_last);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL rst_mid_dump_ready got %b want 1", cmd_ready);
    else n_pass++;
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    n_checks++;
    if (seen || wr_addr_q.size() != n0)
      $display("FAIL rst_mid_dump_quiet got rsp=%0d writes=%0d want 0 0", seen, wr_addr_q.size() - n0);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read(7);
    test_read(10);
    test_dump(2);
    test_clear();
    test_random();
    test_dump(-1);
    test_reset_mid_dump();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
